// File: rtl/rd_sel_arb_enc_if.sv
// rd_sel_arb_enc_if: request/grant bundle between read channels and the queue read mux; lock_i exists only with RD_SEL_LOCK_EN
interface rd_sel_arb_enc_if #(
  parameter int NUM_CH = 4
);
  localparam int IDX_W = $clog2(NUM_CH);
  logic [NUM_CH-1:0] req_i;
  logic              mode_i;
  logic              out_ready_i;
`ifdef RD_SEL_LOCK_EN
  logic              lock_i;
`endif
  logic              grant_valid_o;
  logic [NUM_CH-1:0] grant_o;
  logic [IDX_W-1:0]  grant_idx_o;
  logic              err_o;
`ifdef RD_SEL_LOCK_EN
  modport master (output req_i, mode_i, out_ready_i, lock_i,
                  input grant_valid_o, grant_o, grant_idx_o, err_o);
  modport slave  (input req_i, mode_i, out_ready_i, lock_i,
                  output grant_valid_o, grant_o, grant_idx_o, err_o);
`else
  modport master (output req_i, mode_i, out_ready_i,
                  input grant_valid_o, grant_o, grant_idx_o, err_o);
  modport slave  (input req_i, mode_i, out_ready_i,
                  output grant_valid_o, grant_o, grant_idx_o, err_o);
`endif
endinterface

// File: rtl/rd_sel_arb_enc.sv
// rd_sel_arb_enc: registered one-hot encoder / round-robin arbiter with valid-ready output; RD_SEL_LOCK_EN adds burst lock
module rd_sel_arb_enc #(
  parameter int NUM_CH = 4,
  localparam int IDX_W = $clog2(NUM_CH)
) (
  input logic clk,
  input logic rst,
  rd_sel_arb_enc_if.slave bus
);
  logic [IDX_W-1:0] ptr_q, ptr_nxt, adv_idx, oh_idx, rr_idx, idx_d;
  logic [IDX_W:0]   c;
  logic [NUM_CH-1:0] g_d;
  logic gmode_q, load, accept, lock, one_hot, rr_hit, gv_d, err_d;
  assign load = !bus.grant_valid_o || bus.out_ready_i;
  assign accept = bus.grant_valid_o && bus.out_ready_i;
`ifdef RD_SEL_LOCK_EN
  assign lock = bus.lock_i;
`else
  assign lock = 1'b0;
`endif
  assign one_hot = $onehot(bus.req_i);
  assign adv_idx = (bus.grant_idx_o == IDX_W'(NUM_CH - 1)) ? '0 : bus.grant_idx_o + 1'b1;
  // pointer only moves when a round-robin grant is accepted; a locked accept parks it on the granted channel
  // so the next scan starts there, and the scan uses this next value so back-to-back grants rotate correctly
  assign ptr_nxt = (accept && gmode_q) ? (lock ? bus.grant_idx_o : adv_idx) : ptr_q;
  // binary position of the set bit, meaningful only when req_i is one-hot
  always_comb begin
    oh_idx = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (bus.req_i[i]) oh_idx = IDX_W'(i);
  end
  // scan from ptr_nxt upward with modulo wrap; iterating farthest-first lets the nearest hit win
  always_comb begin
    rr_idx = '0;
    rr_hit = 1'b0;
    c = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      c = {1'b0, ptr_nxt} + (IDX_W + 1)'(i);
      c = (c >= (IDX_W + 1)'(NUM_CH)) ? c - (IDX_W + 1)'(NUM_CH) : c;
      if (bus.req_i[c[IDX_W-1:0]]) begin
        rr_idx = c[IDX_W-1:0];
        rr_hit = 1'b1;
      end
    end
  end
  // next output register contents; outputs hold unless the register is free or being accepted
  always_comb begin
    gv_d = bus.grant_valid_o;
    g_d = bus.grant_o;
    idx_d = bus.grant_idx_o;
    err_d = bus.err_o;
    if (load) begin
      gv_d = bus.mode_i ? rr_hit : one_hot;
      idx_d = gv_d ? (bus.mode_i ? rr_idx : oh_idx) : bus.grant_idx_o;
      err_d = !bus.mode_i && |bus.req_i && !one_hot;
      g_d = gv_d ? NUM_CH'(1) << idx_d : '0;
    end
  end
  // output, pointer and grant-mode registers; gmode_q remembers which mode produced the held grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.grant_valid_o <= 1'b0;
      bus.grant_o <= '0;
      bus.grant_idx_o <= '0;
      bus.err_o <= 1'b0;
      ptr_q <= '0;
      gmode_q <= 1'b0;
    end else begin
      bus.grant_valid_o <= gv_d;
      bus.grant_o <= g_d;
      bus.grant_idx_o <= idx_d;
      bus.err_o <= err_d;
      ptr_q <= ptr_nxt;
      gmode_q <= load ? bus.mode_i : gmode_q;
    end
  end
endmodule

// File: doc/rd_sel_arb_enc.md
Name: rd_sel_arb_enc

Overview:
- Parametrised, registered read-select generator for the multi-channel special queue.
- Takes an N-bit read-request vector and produces a one-hot grant plus its binary index, with a valid/ready handshake toward the queue read mux.
- Two modes:
  - Direct: strict one-hot encode with an error flag on bad input.
  - Round-robin: arbitration among any number of requesters.

Parameters:
- NUM_CH, 4, number of read channels (>= 2; need not be a power of two).
- IDX_W, $clog2(NUM_CH), width of the binary index. Derived; must not be overridden.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_i  input  NUM_CH  read request per channel.
- mode_i  input  1  0 = direct one-hot encode, 1 = round-robin arbitrate.
- out_ready_i  input  1  downstream accepts current grant.
- grant_valid_o  output  1  grant_o / grant_idx_o valid.
- grant_o  output  NUM_CH  one-hot grant.
- grant_idx_o  output  IDX_W  binary index of grant_o.
- err_o  output  1  registered flag: last load in direct mode saw multi-hot req_i.

Behaviour:
- Reset (async assert, sync deassert by system): grant_valid_o=0, grant_o=0, grant_idx_o=0, err_o=0, internal pointer ptr=0.
- Output register load condition: load = !grant_valid_o || out_ready_i. Latency is one cycle from req_i to outputs.
- Holding: when grant_valid_o=1 and out_ready_i=0, all outputs hold stable regardless of req_i or mode_i changes, including a requester dropping its request.
- Accept: accept = grant_valid_o && out_ready_i. A new grant may be loaded in the same edge as an accept, giving back-to-back grants at one per cycle.
- Direct mode (mode_i=0), on load:
  - req_i exactly one-hot: grant_o=req_i, grant_idx_o=bit position, valid=1, err_o=0.
  - req_i==0: valid=0, grant_o=0, err_o=0.
  - req_i multi-hot: valid=0, grant_o=0, err_o=1.
  - grant_idx_o holds its old value whenever valid=0.
  - ptr is not updated in direct mode.
- Round-robin mode (mode_i=1), on load:
  - Select the first set bit of req_i scanning from ptr upward, wrapping from NUM_CH-1 to 0.
  - valid=1 if req_i!=0, else valid=0 with grant_o=0.
  - err_o=0 always.
- ptr update: on accept in round-robin mode, ptr <= (grant_idx_o==NUM_CH-1) ? 0 : grant_idx_o+1. This is a modulo wrap, correct for non-power-of-two NUM_CH.
- Mode change: takes effect at the next load only; a held grant completes unchanged.
- err_o is a status register. It updates only on load, so it persists while no load occurs.
- grant_o is always one-hot or zero. grant_o == (1 << grant_idx_o) whenever valid=1.
- No combinational path from req_i or mode_i to any output. out_ready_i feeds only the load enable.

Optional Feature:
- Macro: RD_SEL_LOCK_EN.
- Defined:
  - Adds input lock_i (1 bit).
  - If lock_i=1 at an accept in round-robin mode, ptr is not advanced.
  - The next load re-grants the same channel if its request bit is still set; otherwise normal scan from ptr.
  - Used for burst reads from one queue.
  - lock_i is ignored in direct mode.
- Undefined:
  - No lock_i port.
  - ptr always advances on a round-robin accept.

Test Plan (NUM_CH=4):
1. Reset mid-operation: grant valid on ch2 with out_ready_i=0, assert rst -> outputs and ptr clear immediately (async). After release with mode_i=1, req_i=4'b0001, the first grant is idx 0 (from ptr=0).
2. Direct encode: mode_i=0, out_ready_i=1, apply req_i 0001, 0010, 0100, 1000 on successive cycles -> one cycle later grant_idx_o = 0, 1, 2, 3 with valid=1, err_o=0. Then req_i=0110 -> valid=0, err_o=1. Then req_i=0000 -> valid=0, err_o=0.
3. Round-robin fairness and wrap: mode_i=1, req_i=4'b1111 constant, out_ready_i=1 -> grant_idx_o sequence 0, 1, 2, 3, 0, 1, with valid held high every cycle.
4. Backpressure hold: req_i=4'b1010, out_ready_i=0 for 5 cycles while req_i changes to 0100 -> grant stays idx 1 / 0010. Raise out_ready_i -> the next grant is idx 2 (ptr=2).
5. Sparse wrap: ptr=3 after granting ch2, req_i=4'b0001 -> grant idx 0. Then req_i=4'b1001 -> grant idx 3 (ptr=1 scans 1, 2, 3).
6. RD_SEL_LOCK_EN only: req_i=1111, lock_i=1 at an accept of idx 1 -> next grant idx 1 again. With lock_i=0 -> next grant idx 2.
